// File: rtl/calc_op_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// calc_op_sequencer_pkg
//   Shared definitions for the calculator operation sequencer and the display
//   path: operation codes, sequencer state encoding, the lamp-test value and
//   small classification helpers.
// ----------------------------------------------------------------------------
package calc_op_sequencer_pkg;

  // Operation codes; the code is also the index of the unit's done bit and
  // result byte. LAMP has no unit behind it.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_DIV  = 3'd2,
    OP_MUL  = 3'd3,
    OP_REM  = 3'd4,
    OP_SQRT = 3'd5,
    OP_POW  = 3'd6,
    OP_LAMP = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [7:0] LAMP_VALUE = 8'hFF;

  // Operations that fault on a zero divisor.
  function automatic logic needs_divisor(op_t op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // States in which an operation is in flight.
  function automatic logic is_busy(state_t s);
    return (s == ST_CHECK) || (s == ST_LAUNCH) || (s == ST_WAIT);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
//   Synchronises a raw push-button, accepts a new level only after it has been
//   stable for DB_CYCLES consecutive cycles, and emits a one-cycle pulse on an
//   accepted rising level.
// Ports
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   raw    in  asynchronous button level
//   pulse  out registered single-cycle press pulse
// ----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter runs only while the synchronised input disagrees with the
  // accepted level; any agreement restarts the stability window.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge only; the level starts low so
    // releasing reset with the button up never produces a pulse.
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the two-stage synchroniser a real pipeline.
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// ----------------------------------------------------------------------------
// calc_op_sequencer
//   Front-panel controller for the calculator arithmetic units. Steps the
//   operation select, latches operands, launches the selected unit with a
//   one-cycle start, waits for its done and captures its result. Reports
//   divide-by-zero and unit timeout on err.
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   btn_next, btn_go  raw buttons: step op_sel / launch current op
//   sw[7:0]           operands, A = sw[3:0], B = sw[7:4]
//   done_vec[6:0]     per-unit done, indexed by op code
//   result_flat[55:0] per-unit results, unit k at [8k+7:8k]
//   op_sel            current op code (7 = LAMP test)
//   operand_a/b       latched operands
//   start             one-cycle launch pulse for unit op_sel
//   result, valid     captured result and completion flag
//   busy              operation in flight (CHECK, LAUNCH, WAIT)
//   err               divide-by-zero or timeout
// ----------------------------------------------------------------------------
module calc_op_sequencer #(
  parameter int DB_CYCLES   = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_go,
  input  logic [7:0]  sw,
  input  logic [6:0]  done_vec,
  input  logic [55:0] result_flat,
  output logic [2:0]  op_sel,
  output logic [3:0]  operand_a,
  output logic [3:0]  operand_b,
  output logic        start,
  output logic [7:0]  result,
  output logic        valid,
  output logic        busy,
  output logic        err
);

  import calc_op_sequencer_pkg::*;

  logic next_pulse, go_pulse;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_next),
    .pulse (next_pulse)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_go (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_go),
    .pulse (go_pulse)
  );

  state_t     state_q, state_d;
  op_t        op_sel_q, op_sel_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [7:0] result_q, result_d;
  logic [7:0] timer_q, timer_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       start_q, start_d;
  logic       busy_q, busy_d;

  // Pad to a power of two so the LAMP code indexes a defined (inactive) slot.
  logic [7:0]  done_ext;
  logic [63:0] result_ext;
  assign done_ext   = {1'b0, done_vec};
  assign result_ext = {8'h00, result_flat};

  always_comb begin
    state_d  = state_q;
    op_sel_d = op_sel_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    timer_d  = timer_q;
    valid_d  = valid_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // go takes priority; a simultaneous next is dropped.
        if (go_pulse) begin
          a_d     = sw[3:0];
          b_d     = sw[7:4];
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end else if (next_pulse) begin
          op_sel_d = op_t'(op_sel_q + 3'd1);
          valid_d  = 1'b0;
        end
      end
      ST_CHECK: begin
        if (needs_divisor(op_sel_q) && (b_q == 4'd0)) begin
          err_d    = 1'b1;
          result_d = 8'h00;
          state_d  = ST_ERROR;
        end else if (op_sel_q == OP_LAMP) begin
          result_d = LAMP_VALUE;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done is checked first so it wins over a same-cycle timeout.
        if (done_ext[op_sel_q]) begin
          result_d = result_ext[{op_sel_q, 3'b000} +: 8];
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
          if (timer_d == 8'(TIMEOUT_CYC)) begin
            err_d    = 1'b1;
            result_d = 8'h00;
            state_d  = ST_ERROR;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs derived from the next state.
    start_d = (state_d == ST_LAUNCH);
    busy_d  = is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_sel_q <= OP_ADD;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      result_q <= 8'h00;
      timer_q  <= 8'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_sel_q <= op_sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      timer_q  <= timer_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

  assign op_sel    = op_sel_q;
  assign operand_a = a_q;
  assign operand_b = b_q;
  assign start     = start_q;
  assign result    = result_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
